// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential signed multiplier using radix-4 modified Booth recoding.
// Latency: capture edge E0, WIDTH/2 iteration edges, result and one-cycle ready pulse on the edge after that.
// Backpressure: none; a new ctrl_MULT restarts the unit from any state (an abort when running).
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   ctrl_MULT             start pulse, operands sampled on the edge where it is high
//   data_operandA/B       two's complement multiplicand / multiplier
//   data_result           low WIDTH bits of A*B
//   data_exception        signed product does not fit in WIDTH bits
//   data_resultRDY        one-cycle pulse, result/exception valid
//   data_busy             operation in progress
module booth_mult_seq #(
  parameter int  WIDTH = 32,
  localparam int ITER  = WIDTH / 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             data_busy
);

  // Accumulator is WIDTH+2 bits so that +/-2A and the running sum never wrap.
  localparam int AW = WIDTH + 2;
  // Product register: {accumulator, multiplier, guard bit}.
  localparam int PW = AW + WIDTH + 1;
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_mcand;
  logic [PW-1:0] r_prod;

  logic [AW-1:0]    w_acc;
  logic [AW-1:0]    w_op;
  logic             w_neg;
  logic [AW-1:0]    w_addend;
  logic [AW-1:0]    w_sum;
  logic [PW-1:0]    w_next;
  logic [PW-1:0]    w_shift;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH:0]   w_hi;
  logic             w_ovf;

  assign w_acc = r_prod[PW-1:WIDTH+1];

  // Booth digit from the current bit pair plus the bit shifted out last time.
  always_comb begin
    w_op  = '0;
    w_neg = 1'b0;
    case (r_prod[2:0])
      3'b001, 3'b010: w_op = r_mcand;
      3'b011:         w_op = {r_mcand[AW-2:0], 1'b0};
      3'b100: begin
        w_op  = {r_mcand[AW-2:0], 1'b0};
        w_neg = 1'b1;
      end
      3'b101, 3'b110: begin
        w_op  = r_mcand;
        w_neg = 1'b1;
      end
      default: begin
        w_op  = '0;
        w_neg = 1'b0;
      end
    endcase
  end

  // Subtraction as invert plus carry-in; carry out of the top bit is dropped.
  assign w_addend = w_op ^ {AW{w_neg}};
  assign w_sum    = w_acc + w_addend + {{(AW-1){1'b0}}, w_neg};
  assign w_next   = {w_sum, r_prod[WIDTH:0]};
  assign w_shift  = {{2{w_next[PW-1]}}, w_next[PW-1:2]};

  // After all iterations the 2*WIDTH-bit product sits at r_prod[2*WIDTH:1].
  assign w_lo  = r_prod[WIDTH:1];
  assign w_hi  = r_prod[2*WIDTH:WIDTH];
  assign w_ovf = ~((&w_hi) | (~|w_hi));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_mcand        <= '0;
      r_prod         <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      data_busy      <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;

      // The result leaves DONE on this edge even if a new start arrives with it.
      if (r_state == S_DONE) begin
        data_resultRDY <= 1'b1;
        data_result    <= w_lo;
        data_exception <= w_ovf;
      end

      if (ctrl_MULT) begin
        r_mcand   <= {{2{data_operandA[WIDTH-1]}}, data_operandA};
        r_prod    <= {{AW{1'b0}}, data_operandB, 1'b0};
        r_cnt     <= '0;
        data_busy <= 1'b1;
        r_state   <= S_RUN;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_IDLE;
          S_RUN: begin
            r_prod <= w_shift;
            r_cnt  <= r_cnt + 1'b1;
            if (r_cnt == CW'(ITER - 1)) begin
              r_state   <= S_DONE;
              data_busy <= 1'b0;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
module tb_booth_mult_seq;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         ctrl_MULT = 1'b0;
  logic [W-1:0] data_operandA = '0;
  logic [W-1:0] data_operandB = '0;
  logic [W-1:0] data_result;
  logic         data_exception;
  logic         data_resultRDY;
  logic         data_busy;

  booth_mult_seq #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .data_busy      (data_busy)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a pending product and the edge it was captured on.
  // The answer appears 17 edges after capture; busy covers the 16 cycles after capture.
  int           cyc = 0;
  int           c0 = 0;
  bit           has_op = 0;
  logic [W-1:0] pend_res = '0;
  logic         pend_exc = 0;
  logic [W-1:0] m_res = '0;
  logic         m_exc = 0;
  logic         m_rdy = 0;
  logic         m_busy = 0;

  function automatic logic [63:0] sprod(input logic [W-1:0] a, input logic [W-1:0] b);
    longint pa, pb;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    return 64'(pa * pb);
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      has_op = 0;
      m_res  = '0;
      m_exc  = 0;
      m_rdy  = 0;
      m_busy = 0;
    end else begin
      logic [63:0] p;
      cyc++;
      m_rdy = 0;
      if (has_op && cyc == c0 + 17) begin
        m_rdy  = 1;
        m_res  = pend_res;
        m_exc  = pend_exc;
        has_op = 0;
      end
      if (ctrl_MULT) begin
        p        = sprod(data_operandA, data_operandB);
        pend_res = p[W-1:0];
        pend_exc = !((p[63:31] == '0) || (p[63:31] == '1));
        has_op   = 1;
        c0       = cyc;
      end
      m_busy = has_op && ((cyc - c0) < 16);
    end
  end

  always @(negedge clock) begin
    chk("rdy", 64'(data_resultRDY), 64'(m_rdy));
    chk("busy", 64'(data_busy), 64'(m_busy));
    chk("result", 64'(data_result), 64'(m_res));
    chk("exception", 64'(data_exception), 64'(m_exc));
  end

  // Drive a one-cycle start; returns just after the negedge following the capture edge.
  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    #2;
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    #2;
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Wait (bounded) for the ready pulse and pin latency, busy length and values.
  task automatic wait_rdy(input string name, input logic [W-1:0] er, input logic ee);
    int n;
    int busy_cnt;
    bit seen;
    n = 0;
    busy_cnt = 1;  // busy was already high in the cycle right after capture
    seen = 0;
    while (!seen && n < 30) begin
      @(negedge clock);
      n++;
      if (data_busy) busy_cnt++;
      if (data_resultRDY) seen = 1;
    end
    chk({name, "_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      chk({name, "_latency"}, 64'(n), 64'd17);
      chk({name, "_busycycles"}, 64'(busy_cnt), 64'd16);
      chk({name, "_res"}, 64'(data_result), 64'(er));
      chk({name, "_exc"}, 64'(data_exception), 64'(ee));
    end
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("reset_result", 64'(data_result), 64'd0);
    chk("reset_exc", 64'(data_exception), 64'd0);
    chk("reset_rdy", 64'(data_resultRDY), 64'd0);
    chk("reset_busy", 64'(data_busy), 64'd0);
    #2 reset = 1'b1;

    start(32'd7, 32'd6);
    wait_rdy("mul7x6", 32'h0000002A, 1'b0);
    start(32'hFFFFFFFD, 32'd5);
    wait_rdy("neg3x5", 32'hFFFFFFF1, 1'b0);
    start(32'h7FFFFFFF, 32'd2);
    wait_rdy("max_x2", 32'hFFFFFFFE, 1'b1);
    start(32'h80000000, 32'hFFFFFFFF);
    wait_rdy("min_xm1", 32'h80000000, 1'b1);
    start(32'hFFFF0000, 32'h00010000);
    wait_rdy("lowzero_ovf", 32'h00000000, 1'b1);

    // Abort: second capture lands on edge 8 of the first operation.
    start(32'd9, 32'd9);
    repeat (6) @(negedge clock);
    start(32'd4, 32'hFFFFFFFC);
    wait_rdy("abort", 32'hFFFFFFF0, 1'b0);

    // Reset in the middle of an operation.
    start(32'd1234, 32'd5678);
    repeat (8) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("midreset_result", 64'(data_result), 64'd0);
    chk("midreset_exc", 64'(data_exception), 64'd0);
    chk("midreset_rdy", 64'(data_resultRDY), 64'd0);
    chk("midreset_busy", 64'(data_busy), 64'd0);
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    start(32'd0, 32'h12345678);
    wait_rdy("zero_x", 32'd0, 1'b0);

    // Random traffic: gaps of 0..20 cycles give aborts, DONE-edge restarts and idle gaps.
    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] a, b;
      case ($urandom_range(0, 5))
        0:       a = 32'h80000000;
        1:       a = 32'h7FFFFFFF;
        2:       a = $urandom_range(0, 15);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       b = 32'hFFFFFFFF;
        1:       b = 32'h80000000;
        2:       b = $urandom_range(0, 40000);
        default: b = $urandom;
      endcase
      start(a, b);
      repeat ($urandom_range(0, 20)) @(negedge clock);
    end
    repeat (25) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
